// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// and presents the oldest returned word as the IF/ID Curr_Pc / Curr_Instr pair.
module if_fetch_stage #(
    parameter int unsigned     PC_W    = 9,
    parameter int unsigned     DEPTH   = 2,
    parameter logic [PC_W-1:0] BOOT_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_id_valid,
    output logic [PC_W-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
);

    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W     = CNT_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             start_q;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
    logic [PTR_W-1:0] buf_rd_q, buf_rd_d;
    logic [PTR_W-1:0] buf_wr_q, buf_wr_d;
    logic [PTR_W-1:0] ifq_rd_q, ifq_rd_d;
    logic [PTR_W-1:0] ifq_wr_q, ifq_wr_d;

    logic [PC_W-1:0]  buf_pc_q    [DEPTH];
    logic [31:0]      buf_instr_q [DEPTH];
    logic [PC_W-1:0]  ifq_pc_q    [DEPTH];

    logic             pop;
    logic             issue;
    logic             fire;
    logic             rsp_keep;
    logic [SUM_W-1:0] credit_used;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit: in-flight requests (including ones to be dropped) plus buffered words
    // may never exceed the buffer depth, so every response always has a slot.
    always_comb begin
        pop         = if_id_valid & ~stall;
        credit_used = SUM_W'(out_cnt_q) + SUM_W'(buf_cnt_q) - SUM_W'(pop);
        issue       = start_q & ~redirect_valid & (credit_used < SUM_W'(DEPTH));
        fire        = issue & imem_req_ready;
        rsp_keep    = imem_rsp_valid & ~redirect_valid & (drop_cnt_q == '0);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        buf_cnt_d  = buf_cnt_q;
        buf_rd_d   = buf_rd_q;
        buf_wr_d   = buf_wr_q;
        ifq_rd_d   = ifq_rd_q;
        ifq_wr_d   = ifq_wr_q;

        // The in-flight PC queue tracks every request, kept or dropped.
        if (fire) begin
            ifq_wr_d = ifq_wr_q + PTR_W'(1);
        end
        if (imem_rsp_valid) begin
            ifq_rd_d = ifq_rd_q + PTR_W'(1);
        end

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
            drop_cnt_d = out_cnt_q - CNT_W'(imem_rsp_valid);
            buf_cnt_d  = '0;
            buf_rd_d   = '0;
            buf_wr_d   = '0;
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + PC_W'(4);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (rsp_keep) begin
                buf_wr_d = buf_wr_q + PTR_W'(1);
            end
            if (pop) begin
                buf_rd_d = buf_rd_q + PTR_W'(1);
            end
            buf_cnt_d = buf_cnt_q + CNT_W'(rsp_keep) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= {BOOT_PC[PC_W-1:2], 2'b00};
            start_q    <= 1'b0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            buf_cnt_q  <= '0;
            buf_rd_q   <= '0;
            buf_wr_q   <= '0;
            ifq_rd_q   <= '0;
            ifq_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            start_q    <= 1'b1;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            buf_cnt_q  <= buf_cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            ifq_rd_q   <= ifq_rd_d;
            ifq_wr_q   <= ifq_wr_d;
        end
    end

    // Payload storage; validity is carried entirely by the counters and pointers.
    always_ff @(posedge clk) begin
        if (fire) begin
            ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            buf_pc_q[buf_wr_q]    <= ifq_pc_q[ifq_rd_q];
            buf_instr_q[buf_wr_q] <= imem_rsp_data;
        end
    end

    assign imem_req_valid = issue;
    assign imem_req_addr  = fetch_pc_q;
    assign if_id_valid    = (buf_cnt_q != '0);
    assign if_id_pc       = if_id_valid ? buf_pc_q[buf_rd_q] : '0;
    assign if_id_instr    = if_id_valid ? buf_instr_q[buf_rd_q] : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: latency-programmable instruction memory, queue-based reference
// model compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_if_fetch_stage;

    localparam int unsigned     PC_W  = 9;
    localparam int unsigned     DEPTH = 2;
    localparam logic [PC_W-1:0] BOOT  = 9'd500;
    localparam logic [31:0]     NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req_valid;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            stall;
    logic            if_id_valid;
    logic [PC_W-1:0] if_id_pc;
    logic [31:0]     if_id_instr;

    always #5 clk = ~clk;

    if_fetch_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .BOOT_PC(BOOT)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    typedef struct { logic [PC_W-1:0] pc; bit stale; } inflight_t;
    typedef struct { logic [PC_W-1:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { logic [PC_W-1:0] addr; int due; } memreq_t;

    inflight_t       m_inf[$];
    entry_t          m_buf[$];
    memreq_t         mq[$];
    logic [PC_W-1:0] m_pc;
    bit              m_started;

    logic [PC_W-1:0] hs_log[$];
    logic [PC_W-1:0] pop_log[$];
    int              hs_first, vis_first, rel;

    int edge_n, lat, last_due;
    int n_tests, n_fail;

    logic [PC_W-1:0] boot_seq [5] = '{9'd500, 9'd504, 9'd508, 9'd0, 9'd4};

    function automatic logic [31:0] memword(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0101_0101);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] log_at(input logic [PC_W-1:0] q[$], input int i);
        if (i < q.size()) return 32'(q[i]);
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_reset();
        m_inf.delete();
        m_buf.delete();
        mq.delete();
        m_pc      = BOOT;
        m_started = 1'b0;
        last_due  = edge_n;
    endtask

    task automatic clear_logs();
        hs_log.delete();
        pop_log.delete();
        hs_first  = -1;
        vis_first = -1;
    endtask

    task automatic mem_drive();
        if (mq.size() != 0 && mq[0].due == edge_n + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Compare DUT with model for the current cycle, then advance model to the next edge.
    task automatic check_and_model();
        bit        exp_v, pop, exp_rv;
        int        occ, due;
        inflight_t e;
        exp_v = (m_buf.size() != 0);
        chk("if_id_valid", 32'(if_id_valid), 32'(exp_v));
        chk("if_id_pc", 32'(if_id_pc), exp_v ? 32'(m_buf[0].pc) : 32'd0);
        chk("if_id_instr", if_id_instr, exp_v ? m_buf[0].instr : NOP);
        pop    = exp_v && !stall;
        occ    = m_inf.size() + m_buf.size() - (pop ? 1 : 0);
        exp_rv = m_started && !redirect_valid && (occ < int'(DEPTH));
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", 32'(imem_req_addr), 32'(m_pc));

        if (imem_req_valid && imem_req_ready) begin
            due = edge_n + 1 + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_req_addr, due: due});
            hs_log.push_back(imem_req_addr);
            if (hs_first < 0) hs_first = edge_n;
        end
        if (if_id_valid && vis_first < 0) vis_first = edge_n;
        if (if_id_valid && !stall && !redirect_valid) pop_log.push_back(if_id_pc);
        if (imem_rsp_valid && mq.size() != 0) void'(mq.pop_front());

        if (redirect_valid) begin
            if (imem_rsp_valid && m_inf.size() != 0) void'(m_inf.pop_front());
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_buf.delete();
            m_pc = {redirect_pc[PC_W-1:2], 2'b00};
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (imem_rsp_valid) begin
                if (m_inf.size() == 0) begin
                    chk("rsp_without_request", 32'd1, 32'd0);
                end else begin
                    e = m_inf.pop_front();
                    if (!e.stale) m_buf.push_back('{pc: e.pc, instr: memword(e.pc)});
                end
            end
            if (exp_rv && imem_req_ready) begin
                m_inf.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + PC_W'(4);
            end
        end
        m_started = 1'b1;
    endtask

    task automatic cycle();
        mem_drive();
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_id_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_if_id_pc"}, 32'(if_id_pc), 32'd0);
        chk({tag, "_if_id_instr"}, if_id_instr, NOP);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        bit              found, ok;
        logic [PC_W-1:0] held_pc;
        n_tests = 0; n_fail = 0; edge_n = 0; lat = 1;
        reset = 1'b0; imem_req_ready = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        model_reset();
        clear_logs();

        // Reset and boot from 500: wraps through 508 -> 0
        repeat (3) @(posedge clk);
        #1; edge_n += 3;
        chk_reset_outputs("reset");
        reset = 1'b1; rel = edge_n; model_reset(); clear_logs();
        repeat (12) cycle();
        chk("boot_first_req_cycle", 32'(hs_first - rel), 32'd1);
        chk("boot_first_valid_lag", 32'(vis_first - hs_first), 32'd2);
        chk("boot_req_count", 32'(hs_log.size()), 32'd11);
        chk("boot_pop_count", 32'(pop_log.size()), 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk("boot_req_addr", log_at(hs_log, i), 32'(boot_seq[i]));
            chk("boot_if_id_pc", log_at(pop_log, i), 32'(boot_seq[i]));
        end

        // Stall five cycles: head held, fetch blocked once the buffer fills
        held_pc = if_id_pc;
        for (int k = 0; k < 5; k++) begin
            stall = 1'b1;
            cycle();
            chk("stall_valid", 32'(if_id_valid), 32'd1);
            chk("stall_pc_held", 32'(if_id_pc), 32'(held_pc));
            chk("stall_req_blocked", 32'(imem_req_valid), 32'd0);
        end
        stall = 1'b0;
        repeat (10) cycle();
        ok = 1'b1;
        for (int i = 1; i < pop_log.size(); i++)
            if (pop_log[i] != pop_log[i-1] + PC_W'(4)) ok = 1'b0;
        chk("stall_no_gap_or_dup", 32'(ok), 32'd1);

        // Redirect to 0x40 with two requests outstanding at L=3
        lat = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_inf.size() == 2 && !(mq.size() != 0 && mq[0].due == edge_n + 1)) found = 1'b1;
            else cycle();
        end
        chk("redirect_setup_found", 32'(found), 32'd1);
        clear_logs();
        redirect_valid = 1'b1; redirect_pc = 9'h040;
        cycle();
        redirect_valid = 1'b0;
        chk("redirect_outputs_empty", 32'(if_id_valid), 32'd0);
        repeat (20) cycle();
        chk("redirect_first_req", log_at(hs_log, 0), 32'h40);
        chk("redirect_first_pc", log_at(pop_log, 0), 32'h40);
        chk("redirect_second_pc", log_at(pop_log, 1), 32'h44);

        // Redirect colliding with a response and a pop; low target bits ignored
        lat = 1;
        repeat (6) cycle();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_buf.size() != 0 && mq.size() != 0 && mq[0].due == edge_n + 1) found = 1'b1;
            else cycle();
        end
        chk("collide_setup_found", 32'(found), 32'd1);
        clear_logs();
        redirect_valid = 1'b1; redirect_pc = 9'h1F3;
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("collide_empty", 32'(if_id_valid), 32'd0);
        chk("collide_req_valid", 32'(imem_req_valid), 32'd1);
        chk("collide_req_addr", 32'(imem_req_addr), 32'h1F0);
        repeat (10) cycle();
        chk("collide_first_pc", log_at(pop_log, 0), 32'h1F0);

        // Asynchronous reset between edges with a full buffer
        stall = 1'b1;
        for (int k = 0; k < 10 && m_buf.size() != 2; k++) cycle();
        chk("areset_buffer_full", 32'(if_id_valid), 32'd1);
        #2;
        reset = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk_reset_outputs("areset");
        @(posedge clk); @(posedge clk);
        #1; edge_n += 2;
        model_reset(); clear_logs();
        stall = 1'b0; reset = 1'b1; rel = edge_n;
        repeat (8) cycle();
        chk("areset_first_req_cycle", 32'(hs_first - rel), 32'd1);
        chk("areset_first_req", log_at(hs_log, 0), 32'(BOOT));
        chk("areset_first_pc", log_at(pop_log, 0), 32'(BOOT));

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = PC_W'($urandom);
            lat            = int'($urandom_range(1, 4));
            cycle();
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_req_ready = 1'b1;
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
